reg_bank_encap_extended: RTL and testbench
==========================================

# reg_bank_encap_extended

ARMv4 register file with operand-address selection, tri-state bus drivers, program-counter update logic and three register-index counters for multi-register transfers. It sits between the control state machine and the datapath busses. It reads Rn onto A_BUS, Rm onto B_BUS and Rs onto C_BUS, and writes ALU or memory-read results back.

## Interface
No parameters. Control widths are 1 bit unless stated.
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-low reset
- LATCH_REG  in  1  write selected data into Rd-address register
- WRITE_BACK  in  1  write ALU_BUS into Rn-address register (base update)
- IR_RD_MUX  in  1  Rd addr source: 0 IR Rd field, 1 RD counter
- IR_RN_MUX  in  1  Rn addr source: 0 IR Rn field, 1 IR Rd field
- IR_RM_MUX  in  1  Rm addr source: 0 IR[3:0], 1 RM counter
- RD_MUX  in  1  0 IR_RD_MUX result, 1 force R14 (link)
- RN_MUX  in  1  0 IR_RN_MUX result, 1 force R15
- RS_MUX  in  1  Rs addr: 0 IR[11:8], 1 RS counter
- PC_MUX  in  2  PC update: 00 hold, 01 PC+4, 10 ALU_BUS, 11 hold
- DATA_MUX  in  1  Rd write data: 0 ALU_BUS, 1 B_BUS
- REG_GATE_B, REG_GATE_C  in  1  drive Rm onto B_BUS / Rs onto C_BUS
- IR  in  32  instruction register
- ALU_BUS  in  32  ALU result
- is_DPI, is_DPIS, is_DPRS  in  1  data-processing family flags
- RST_RM_CNTR, RST_RS_CNTR, RST_RD_CNTR  in  1  synchronous counter reset
- LATCH_RM_CNTR, LATCH_RS_CNTR, LATCH_RD_CNTR  in  1  counter advance
- RST_REG  in  1  synchronous clear of all 16 registers
- A_BUS  out  32  R[Rn addr], always driven
- B_BUS  inout  32  R[Rm addr] when REG_GATE_B, else Z
- C_BUS  out  32  R[Rs addr] when REG_GATE_C, else Z
- ST  out  32  R[Rd addr] (store data)
- PC  out  32  R15
- RM_CNTR_DONE  out  1  no set register-list bit above RM counter

## Operation
- 16 × 32-bit registers R0–R15. R15 is the PC.
- Field map:
  - If any of is_DPI/is_DPIS/is_DPRS is set: Rd=IR[15:12], Rn=IR[19:16].
  - Otherwise (multiply-style encoding): Rd=IR[19:16], Rn=IR[15:12].
- Address chains:
  - Rd addr = RD_MUX ? 14 : (IR_RD_MUX ? rd_cnt : Rd field).
  - Rn addr = RN_MUX ? 15 : (IR_RN_MUX ? Rd field : Rn field).
- Reads are combinational and return stored values, with no +8 PC offset.
- Write priority per register, highest first:
  1. RST_REG
  2. LATCH_REG
  3. WRITE_BACK
  4. PC_MUX (R15 only)
- A lower-priority write to the same register is dropped.
- PC_MUX=01: R15 <= R15+4, modulo 2^32. PC_MUX=10: R15 <= ALU_BUS.
- RM counter (register-list scan over IR[15:0]):
  - RST_RM_CNTR loads the index of the lowest set bit, or 0 if the list is empty.
  - LATCH_RM_CNTR advances to the next higher set bit. If there is none, it holds.
  - RM_CNTR_DONE = 1 when no bit above the current index is set. This includes the empty-list case.
- RS and RD counters: 4-bit, plain increment modulo 16 on LATCH, cleared to 0 on RST.
- If a counter's RST and LATCH are asserted together, RST wins.

## Timing
- Async reset (rst=0): all registers and counters are 0 immediately. Outputs follow combinationally:
  - A_BUS=0, ST=0, PC=0.
  - RM_CNTR_DONE is a combinational function of IR.
  - B_BUS/C_BUS are Z unless gated.
- All writes and counter updates occur on the rising clk edge while rst=1. Results are visible on the read ports in the same cycle after the edge, so write-to-read latency is 1 cycle.
- Reads during a write cycle return the old value (no bypass).
- Bus gating is purely combinational; there is no clock latency.

## Test plan
- Reset → release: PC=0, A_BUS=0. PC_MUX=01 for 3 cycles → PC=12. PC_MUX=10 with ALU_BUS=0x100 → PC=0x100.
- is_DPI=1, IR Rd=3, LATCH_REG, DATA_MUX=0, ALU_BUS=0xDEADBEEF → R3=0xDEADBEEF. Then IR Rn=3 → A_BUS=0xDEADBEEF.
- Simultaneous LATCH_REG (Rd=15, ALU_BUS=0x40) and PC_MUX=01 → PC=0x40. WRITE_BACK and LATCH_REG to the same register → LATCH_REG data is kept.
- IR[15:0]=0x8005, RST_RM_CNTR, IR_RM_MUX=1, REG_GATE_B:
  - B_BUS reads R0, DONE=0.
  - Latch → R2, DONE=0.
  - Latch → R15, DONE=1.
  - Further latch → holds at R15.
- REG_GATE_B=0 with an external driver on B_BUS=0x55, DATA_MUX=1, LATCH_REG → Rd=0x55. Assert rst=0 mid-sequence → all registers read 0 immediately.

Source files
------------

// File: rtl/reg_bank_encap_extended.sv
// rtl/reg_bank_encap_extended.sv - ARMv4 register file with operand addressing, bus drivers, PC update and transfer counters
module reg_bank_encap_extended (
    input  logic        clk,
    input  logic        rst,
    input  logic        LATCH_REG,
    input  logic        WRITE_BACK,
    input  logic        IR_RD_MUX,
    input  logic        IR_RN_MUX,
    input  logic        IR_RM_MUX,
    input  logic        RD_MUX,
    input  logic        RN_MUX,
    input  logic        RS_MUX,
    input  logic [1:0]  PC_MUX,
    input  logic        DATA_MUX,
    input  logic        REG_GATE_B,
    input  logic        REG_GATE_C,
    input  logic [31:0] IR,
    input  logic [31:0] ALU_BUS,
    input  logic        is_DPI,
    input  logic        is_DPIS,
    input  logic        is_DPRS,
    input  logic        RST_RM_CNTR,
    input  logic        RST_RS_CNTR,
    input  logic        RST_RD_CNTR,
    input  logic        LATCH_RM_CNTR,
    input  logic        LATCH_RS_CNTR,
    input  logic        LATCH_RD_CNTR,
    input  logic        RST_REG,
    output logic [31:0] A_BUS,
    inout  wire  [31:0] B_BUS,
    output logic [31:0] C_BUS,
    output logic [31:0] ST,
    output logic [31:0] PC,
    output logic        RM_CNTR_DONE
);

    logic [31:0] regs_q [16];
    logic [31:0] regs_d [16];

    logic [3:0]  rm_cnt_q, rm_cnt_d;
    logic [3:0]  rs_cnt_q, rs_cnt_d;
    logic [3:0]  rd_cnt_q, rd_cnt_d;

    logic        is_dp;
    logic [3:0]  rd_field, rn_field;
    logic [3:0]  rd_addr, rn_addr, rm_addr, rs_addr;
    logic [31:0] rm_val, rs_val, wr_data;
    logic [15:0] reg_list;
    logic [3:0]  rm_first, rm_next;
    logic        rm_has_next;
    logic        unused_ir;

    assign unused_ir = ^IR[31:20];

    // Data-processing encodings swap the Rd/Rn nibbles relative to multiply-style ones
    assign is_dp    = is_DPI | is_DPIS | is_DPRS;
    assign rd_field = is_dp ? IR[15:12] : IR[19:16];
    assign rn_field = is_dp ? IR[19:16] : IR[15:12];

    assign rd_addr = RD_MUX ? 4'd14 : (IR_RD_MUX ? rd_cnt_q : rd_field);
    assign rn_addr = RN_MUX ? 4'd15 : (IR_RN_MUX ? rd_field : rn_field);
    assign rm_addr = IR_RM_MUX ? rm_cnt_q : IR[3:0];
    assign rs_addr = RS_MUX ? rs_cnt_q : IR[11:8];

    assign rm_val = regs_q[rm_addr];
    assign rs_val = regs_q[rs_addr];

    assign A_BUS = regs_q[rn_addr];
    assign ST    = regs_q[rd_addr];
    assign PC    = regs_q[15];
    assign B_BUS = REG_GATE_B ? rm_val : 32'hzzzz_zzzz;
    assign C_BUS = REG_GATE_C ? rs_val : 32'hzzzz_zzzz;

    assign wr_data = DATA_MUX ? B_BUS : ALU_BUS;

    // Register-list scan: lowest set bit, and next set bit above the current index
    assign reg_list = IR[15:0];

    always_comb begin
        rm_first = 4'd0;
        for (int i = 15; i >= 0; i--) begin
            if (reg_list[i]) begin
                rm_first = 4'(i);
            end
        end
    end

    always_comb begin
        rm_next     = rm_cnt_q;
        rm_has_next = 1'b0;
        for (int i = 15; i >= 0; i--) begin
            if (reg_list[i] && (i > int'(rm_cnt_q))) begin
                rm_next     = 4'(i);
                rm_has_next = 1'b1;
            end
        end
    end

    assign RM_CNTR_DONE = ~rm_has_next;

    always_comb begin
        rm_cnt_d = rm_cnt_q;
        if (RST_RM_CNTR) begin
            rm_cnt_d = rm_first;
        end else if (LATCH_RM_CNTR) begin
            rm_cnt_d = rm_next;
        end
    end

    always_comb begin
        rs_cnt_d = rs_cnt_q;
        if (RST_RS_CNTR) begin
            rs_cnt_d = 4'd0;
        end else if (LATCH_RS_CNTR) begin
            rs_cnt_d = rs_cnt_q + 4'd1;
        end
    end

    always_comb begin
        rd_cnt_d = rd_cnt_q;
        if (RST_RD_CNTR) begin
            rd_cnt_d = 4'd0;
        end else if (LATCH_RD_CNTR) begin
            rd_cnt_d = rd_cnt_q + 4'd1;
        end
    end

    // Writes are applied lowest priority first so later ones override earlier ones
    always_comb begin
        for (int i = 0; i < 16; i++) begin
            regs_d[i] = regs_q[i];
        end
        if (PC_MUX == 2'b01) begin
            regs_d[15] = regs_q[15] + 32'd4;
        end else if (PC_MUX == 2'b10) begin
            regs_d[15] = ALU_BUS;
        end
        if (WRITE_BACK) begin
            regs_d[rn_addr] = ALU_BUS;
        end
        if (LATCH_REG) begin
            regs_d[rd_addr] = wr_data;
        end
        if (RST_REG) begin
            for (int i = 0; i < 16; i++) begin
                regs_d[i] = 32'd0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < 16; i++) begin
                regs_q[i] <= 32'd0;
            end
            rm_cnt_q <= 4'd0;
            rs_cnt_q <= 4'd0;
            rd_cnt_q <= 4'd0;
        end else begin
            for (int i = 0; i < 16; i++) begin
                regs_q[i] <= regs_d[i];
            end
            rm_cnt_q <= rm_cnt_d;
            rs_cnt_q <= rs_cnt_d;
            rd_cnt_q <= rd_cnt_d;
        end
    end

endmodule

// File: tb/tb_reg_bank_encap_extended.sv
// tb/tb_reg_bank_encap_extended.sv - directed self-checking bench for reg_bank_encap_extended
module tb_reg_bank_encap_extended;

    logic        clk = 1'b0;
    logic        rst;
    logic        LATCH_REG, WRITE_BACK, IR_RD_MUX, IR_RN_MUX, IR_RM_MUX;
    logic        RD_MUX, RN_MUX, RS_MUX, DATA_MUX, REG_GATE_B, REG_GATE_C;
    logic [1:0]  PC_MUX;
    logic [31:0] IR, ALU_BUS;
    logic        is_DPI, is_DPIS, is_DPRS;
    logic        RST_RM_CNTR, RST_RS_CNTR, RST_RD_CNTR;
    logic        LATCH_RM_CNTR, LATCH_RS_CNTR, LATCH_RD_CNTR, RST_REG;
    logic [31:0] A_BUS, C_BUS, ST, PC;
    logic        RM_CNTR_DONE;
    wire  [31:0] B_BUS;
    logic        tb_b_en;
    logic [31:0] tb_b_val;

    int tests = 0;
    int errors = 0;

    assign B_BUS = tb_b_en ? tb_b_val : 32'hzzzz_zzzz;

    always #5 clk = ~clk;

    reg_bank_encap_extended dut (
        .clk(clk), .rst(rst), .LATCH_REG(LATCH_REG), .WRITE_BACK(WRITE_BACK),
        .IR_RD_MUX(IR_RD_MUX), .IR_RN_MUX(IR_RN_MUX), .IR_RM_MUX(IR_RM_MUX),
        .RD_MUX(RD_MUX), .RN_MUX(RN_MUX), .RS_MUX(RS_MUX), .PC_MUX(PC_MUX),
        .DATA_MUX(DATA_MUX), .REG_GATE_B(REG_GATE_B), .REG_GATE_C(REG_GATE_C),
        .IR(IR), .ALU_BUS(ALU_BUS), .is_DPI(is_DPI), .is_DPIS(is_DPIS), .is_DPRS(is_DPRS),
        .RST_RM_CNTR(RST_RM_CNTR), .RST_RS_CNTR(RST_RS_CNTR), .RST_RD_CNTR(RST_RD_CNTR),
        .LATCH_RM_CNTR(LATCH_RM_CNTR), .LATCH_RS_CNTR(LATCH_RS_CNTR), .LATCH_RD_CNTR(LATCH_RD_CNTR),
        .RST_REG(RST_REG), .A_BUS(A_BUS), .B_BUS(B_BUS), .C_BUS(C_BUS), .ST(ST), .PC(PC),
        .RM_CNTR_DONE(RM_CNTR_DONE)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        LATCH_REG = 0; WRITE_BACK = 0; IR_RD_MUX = 0; IR_RN_MUX = 0; IR_RM_MUX = 0;
        RD_MUX = 0; RN_MUX = 0; RS_MUX = 0; PC_MUX = 2'b00; DATA_MUX = 0;
        REG_GATE_B = 0; REG_GATE_C = 0; IR = 32'd0; ALU_BUS = 32'd0;
        is_DPI = 0; is_DPIS = 0; is_DPRS = 0;
        RST_RM_CNTR = 0; RST_RS_CNTR = 0; RST_RD_CNTR = 0;
        LATCH_RM_CNTR = 0; LATCH_RS_CNTR = 0; LATCH_RD_CNTR = 0; RST_REG = 0;
        tb_b_en = 0; tb_b_val = 32'd0;
    endtask

    task automatic write_reg(input logic [3:0] r, input logic [31:0] v);
        idle();
        is_DPI = 1; IR = {16'd0, r, 12'd0}; ALU_BUS = v; LATCH_REG = 1;
        tick();
        idle();
    endtask

    task automatic test_reset();
        idle();
        rst = 0;
        #3;
        tests++; if (PC !== 32'd0) begin errors++; $display("FAIL reset_pc got %h exp %h", PC, 32'd0); end
        tests++; if (A_BUS !== 32'd0) begin errors++; $display("FAIL reset_a_bus got %h exp %h", A_BUS, 32'd0); end
        tests++; if (ST !== 32'd0) begin errors++; $display("FAIL reset_st got %h exp %h", ST, 32'd0); end
        tests++; if (RM_CNTR_DONE !== 1'b1) begin errors++; $display("FAIL reset_done_empty got %b exp 1", RM_CNTR_DONE); end
        tick();
        rst = 1;
        tick();
        tests++; if (PC !== 32'd0) begin errors++; $display("FAIL release_pc got %h exp %h", PC, 32'd0); end
    endtask

    task automatic test_pc_update();
        idle();
        PC_MUX = 2'b01;
        repeat (3) tick();
        tests++; if (PC !== 32'd12) begin errors++; $display("FAIL pc_inc3 got %h exp %h", PC, 32'd12); end
        PC_MUX = 2'b10; ALU_BUS = 32'h100;
        tick();
        tests++; if (PC !== 32'h100) begin errors++; $display("FAIL pc_load got %h exp %h", PC, 32'h100); end
        PC_MUX = 2'b11; ALU_BUS = 32'h777;
        tick();
        tests++; if (PC !== 32'h100) begin errors++; $display("FAIL pc_hold11 got %h exp %h", PC, 32'h100); end
        idle();
    endtask

    task automatic test_reg_write();
        idle();
        is_DPI = 1; IR = 32'h0003_3000; ALU_BUS = 32'hDEADBEEF; LATCH_REG = 1;
        #1;
        tests++; if (A_BUS !== 32'd0) begin errors++; $display("FAIL no_bypass got %h exp %h", A_BUS, 32'd0); end
        tick();
        LATCH_REG = 0;
        #1;
        tests++; if (A_BUS !== 32'hDEADBEEF) begin errors++; $display("FAIL r3_a_bus got %h exp %h", A_BUS, 32'hDEADBEEF); end
        is_DPI = 0; IR = 32'h0003_5000;
        #1;
        tests++; if (ST !== 32'hDEADBEEF) begin errors++; $display("FAIL mul_rd_field got %h exp %h", ST, 32'hDEADBEEF); end
        tests++; if (A_BUS !== 32'd0) begin errors++; $display("FAIL mul_rn_field got %h exp %h", A_BUS, 32'd0); end
        idle();
    endtask

    task automatic test_priority();
        idle();
        is_DPI = 1; IR = 32'h0000_F000; ALU_BUS = 32'h40; LATCH_REG = 1; PC_MUX = 2'b01;
        tick();
        tests++; if (PC !== 32'h40) begin errors++; $display("FAIL latch_over_pc got %h exp %h", PC, 32'h40); end
        idle();
        is_DPI = 1; IR = 32'h0004_4003; REG_GATE_B = 1; DATA_MUX = 1;
        LATCH_REG = 1; WRITE_BACK = 1; ALU_BUS = 32'h1234;
        tick();
        LATCH_REG = 0; WRITE_BACK = 0;
        #1;
        tests++; if (A_BUS !== 32'hDEADBEEF) begin errors++; $display("FAIL latch_over_wb got %h exp %h", A_BUS, 32'hDEADBEEF); end
        idle();
        is_DPI = 1; IR = 32'h0006_4000; WRITE_BACK = 1; ALU_BUS = 32'h666;
        tick();
        WRITE_BACK = 0;
        #1;
        tests++; if (A_BUS !== 32'h666) begin errors++; $display("FAIL write_back got %h exp %h", A_BUS, 32'h666); end
        tests++; if (ST !== 32'hDEADBEEF) begin errors++; $display("FAIL wb_rd_untouched got %h exp %h", ST, 32'hDEADBEEF); end
        idle();
        RN_MUX = 1; WRITE_BACK = 1; ALU_BUS = 32'h200; PC_MUX = 2'b01;
        tick();
        tests++; if (PC !== 32'h200) begin errors++; $display("FAIL wb_over_pc got %h exp %h", PC, 32'h200); end
        idle();
        RD_MUX = 1; LATCH_REG = 1; ALU_BUS = 32'hABC;
        tick();
        LATCH_REG = 0;
        #1;
        tests++; if (ST !== 32'hABC) begin errors++; $display("FAIL link_r14 got %h exp %h", ST, 32'hABC); end
        idle();
    endtask

    task automatic test_rm_counter();
        write_reg(4'd0, 32'h10);
        write_reg(4'd2, 32'h22);
        IR = 32'h0000_8005; IR_RM_MUX = 1; REG_GATE_B = 1; RST_RM_CNTR = 1;
        tick();
        RST_RM_CNTR = 0;
        #1;
        tests++; if (B_BUS !== 32'h10) begin errors++; $display("FAIL rm_first got %h exp %h", B_BUS, 32'h10); end
        tests++; if (RM_CNTR_DONE !== 1'b0) begin errors++; $display("FAIL rm_done0 got %b exp 0", RM_CNTR_DONE); end
        LATCH_RM_CNTR = 1;
        tick();
        tests++; if (B_BUS !== 32'h22) begin errors++; $display("FAIL rm_second got %h exp %h", B_BUS, 32'h22); end
        tests++; if (RM_CNTR_DONE !== 1'b0) begin errors++; $display("FAIL rm_done2 got %b exp 0", RM_CNTR_DONE); end
        tick();
        tests++; if (B_BUS !== 32'h200) begin errors++; $display("FAIL rm_r15 got %h exp %h", B_BUS, 32'h200); end
        tests++; if (RM_CNTR_DONE !== 1'b1) begin errors++; $display("FAIL rm_done15 got %b exp 1", RM_CNTR_DONE); end
        tick();
        tests++; if (B_BUS !== 32'h200) begin errors++; $display("FAIL rm_hold got %h exp %h", B_BUS, 32'h200); end
        RST_RM_CNTR = 1;
        tick();
        tests++; if (B_BUS !== 32'h10) begin errors++; $display("FAIL rm_rst_wins got %h exp %h", B_BUS, 32'h10); end
        idle();
    endtask

    task automatic test_rs_rd_counters();
        idle();
        RS_MUX = 1; REG_GATE_C = 1; RST_RS_CNTR = 1;
        tick();
        RST_RS_CNTR = 0;
        #1;
        tests++; if (C_BUS !== 32'h10) begin errors++; $display("FAIL rs_zero got %h exp %h", C_BUS, 32'h10); end
        LATCH_RS_CNTR = 1;
        repeat (2) tick();
        LATCH_RS_CNTR = 0;
        #1;
        tests++; if (C_BUS !== 32'h22) begin errors++; $display("FAIL rs_two got %h exp %h", C_BUS, 32'h22); end
        idle();
        IR_RD_MUX = 1; RST_RD_CNTR = 1; LATCH_RD_CNTR = 1;
        tick();
        RST_RD_CNTR = 0;
        #1;
        tests++; if (ST !== 32'h10) begin errors++; $display("FAIL rd_rst_wins got %h exp %h", ST, 32'h10); end
        repeat (2) tick();
        tests++; if (ST !== 32'h22) begin errors++; $display("FAIL rd_two got %h exp %h", ST, 32'h22); end
        repeat (14) tick();
        LATCH_RD_CNTR = 0;
        #1;
        tests++; if (ST !== 32'h10) begin errors++; $display("FAIL rd_wrap got %h exp %h", ST, 32'h10); end
        idle();
    endtask

    task automatic test_external_bus();
        idle();
        tb_b_en = 1; tb_b_val = 32'h55; DATA_MUX = 1; LATCH_REG = 1;
        is_DPI = 1; IR = 32'h0007_7000; ALU_BUS = 32'h99;
        tick();
        LATCH_REG = 0;
        #1;
        tests++; if (A_BUS !== 32'h55) begin errors++; $display("FAIL ext_b_bus got %h exp %h", A_BUS, 32'h55); end
        idle();
    endtask

    task automatic test_rst_reg();
        idle();
        is_DPI = 1; IR = 32'h0007_7000; RST_REG = 1; LATCH_REG = 1; ALU_BUS = 32'h77; PC_MUX = 2'b01;
        tick();
        idle();
        is_DPI = 1; IR = 32'h0007_7000;
        #1;
        tests++; if (A_BUS !== 32'd0) begin errors++; $display("FAIL rst_reg_r7 got %h exp %h", A_BUS, 32'd0); end
        tests++; if (PC !== 32'd0) begin errors++; $display("FAIL rst_reg_pc got %h exp %h", PC, 32'd0); end
        idle();
    endtask

    task automatic test_async_reset();
        idle();
        PC_MUX = 2'b01;
        tick();
        idle();
        write_reg(4'd7, 32'h99);
        is_DPI = 1; IR = 32'h0007_7000;
        #1;
        tests++; if (A_BUS !== 32'h99) begin errors++; $display("FAIL pre_async_r7 got %h exp %h", A_BUS, 32'h99); end
        tests++; if (PC !== 32'd4) begin errors++; $display("FAIL pre_async_pc got %h exp %h", PC, 32'd4); end
        rst = 0;
        #1;
        tests++; if (A_BUS !== 32'd0) begin errors++; $display("FAIL async_a_bus got %h exp %h", A_BUS, 32'd0); end
        tests++; if (ST !== 32'd0) begin errors++; $display("FAIL async_st got %h exp %h", ST, 32'd0); end
        tests++; if (PC !== 32'd0) begin errors++; $display("FAIL async_pc got %h exp %h", PC, 32'd0); end
        tick();
        rst = 1;
        idle();
    endtask

    initial begin
        rst = 0;
        idle();
        test_reset();
        test_pc_update();
        test_reg_write();
        test_priority();
        test_rm_counter();
        test_rs_rd_counters();
        test_external_bus();
        test_rst_reg();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", tests, errors);
        $finish;
    end

endmodule
